// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
// Contents:
//   state_t        RUN / STALL controller states
//   FWD_*          ALU operand source encodings driven on fwd_a / fwd_b
//   reg_match()    producer-to-operand register match (register 0 never matches)
package hazard_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Addresses arrive zero-extended so one helper serves any REGW up to 32.
    function automatic logic reg_match(
        input logic        we,
        input logic [31:0] dest,
        input logic [31:0] r
    );
        return we && (dest != 32'd0) && (dest == r);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - ALU operand forwarding select for the instruction in ID/EX
// Parameters:
//   REGW          register-address width
// Ports:
//   ex_rs, ex_rt  in   source registers of the instruction in ID/EX
//   mem_dest      in   EX/MEM destination register
//   mem_regwrite  in   EX/MEM write enable
//   wb_dest       in   MEM/WB destination register
//   wb_regwrite   in   MEM/WB write enable
//   fwd_a, fwd_b  out  operand source select (FWD_REG / FWD_MEM / FWD_WB)
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] ex_rs,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] mem_dest,
    input  logic            mem_regwrite,
    input  logic [REGW-1:0] wb_dest,
    input  logic            wb_regwrite,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic mem_hit_a;
    logic mem_hit_b;
    logic wb_hit_a;
    logic wb_hit_b;

    assign mem_hit_a = reg_match(mem_regwrite, 32'(mem_dest), 32'(ex_rs));
    assign mem_hit_b = reg_match(mem_regwrite, 32'(mem_dest), 32'(ex_rt));
    assign wb_hit_a  = reg_match(wb_regwrite,  32'(wb_dest),  32'(ex_rs));
    assign wb_hit_b  = reg_match(wb_regwrite,  32'(wb_dest),  32'(ex_rt));

    // EX/MEM holds the younger result, so it wins when both stages match.
    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (mem_hit_a) begin
            fwd_a = FWD_MEM;
        end else if (wb_hit_a) begin
            fwd_a = FWD_WB;
        end
        if (mem_hit_b) begin
            fwd_b = FWD_MEM;
        end else if (wb_hit_b) begin
            fwd_b = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - pipeline stall / flush / forwarding controller
// Build option: HAZARD_CTL_FORWARDING_EN (defined: forwarding with load-use
// stall of one cycle; undefined: no forwarding, interlock on EX and MEM producers)
// Parameters:
//   REGW                          register-address width
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rt      operands of the instruction in IF/ID
//   ex_rs, ex_rt                  operands of the instruction in ID/EX
//   ex_dest, ex_regwrite,
//   ex_memread                    ID/EX producer
//   mem_dest, mem_regwrite        EX/MEM producer
//   wb_dest, wb_regwrite          MEM/WB producer
//   branch_taken                  resolved taken branch in EX/MEM
//   pc_write, ifid_write          PC and IF/ID load enables
//   pc_src                        select branch target as next PC
//   ifid_flush, idex_flush,
//   exmem_flush                   bubble insertion per pipeline register
//   fwd_a, fwd_b                  ALU operand source selects
//   stall_cycles, flush_events    saturating performance counters
module hazard_ctl
    import hazard_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic [REGW-1:0] ex_rs,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] ex_dest,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [REGW-1:0] mem_dest,
    input  logic            mem_regwrite,
    input  logic [REGW-1:0] wb_dest,
    input  logic            wb_regwrite,
    input  logic            branch_taken,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            pc_src,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [15:0]     stall_cycles,
    output logic [15:0]     flush_events
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] cnt;
    logic [1:0] cnt_nx;
    logic [1:0] need;
    logic       stall;
    logic       hit_ex;

    // Does the ID/EX producer feed an operand of the instruction being decoded?
    assign hit_ex = reg_match(ex_regwrite, 32'(ex_dest), 32'(id_rs))
                 || (id_uses_rt && reg_match(ex_regwrite, 32'(ex_dest), 32'(id_rt)));

`ifdef HAZARD_CTL_FORWARDING_EN
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // Only a load in EX cannot be forwarded in time.
    assign need = (ex_memread && hit_ex) ? 2'd1 : 2'd0;

    fwd_unit #(
        .REGW (REGW)
    ) u_fwd_unit (
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .fwd_a        (fwd_a_raw),
        .fwd_b        (fwd_b_raw)
    );

    assign fwd_a = rst ? FWD_REG : fwd_a_raw;
    assign fwd_b = rst ? FWD_REG : fwd_b_raw;
`else
    logic hit_mem;
    logic unused_fwd_inputs;

    assign hit_mem = reg_match(mem_regwrite, 32'(mem_dest), 32'(id_rs))
                  || (id_uses_rt && reg_match(mem_regwrite, 32'(mem_dest), 32'(id_rt)));

    // Without forwarding the consumer waits until the producer reaches WB,
    // where the regfile's write-before-read takes over.
    assign need = hit_ex ? 2'd2 : (hit_mem ? 2'd1 : 2'd0);

    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;

    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_dest, wb_regwrite, ex_memread};
`endif

    // Next state. A taken branch squashes whatever is stalled behind it.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        if (branch_taken) begin
            state_nx = RUN;
            cnt_nx   = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need == 2'd2) begin
                            // This cycle is the first bubble; STALL covers the rest.
                            state_nx = STALL;
                            cnt_nx   = 2'd1;
                        end
                    end
                end
                STALL: begin
                    stall = 1'b1;
                    if (cnt <= 2'd1) begin
                        state_nx = RUN;
                        cnt_nx   = 2'd0;
                    end else begin
                        cnt_nx = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = 2'd0;
                end
            endcase
        end
    end

    // Control outputs. Reset forces the quiet, non-advancing pattern.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            if (!pc_write && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
            if (branch_taken && (flush_events != 16'hFFFF)) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// tb/tb_hazard_ctl.sv - randomized and directed self-checking bench for hazard_ctl
module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
    logic        branch_taken;
    logic        pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    // Reference model: number of bubble cycles still owed, plus counters.
    int stall_left = 0;
    int m_stall    = 0;
    int m_flush    = 0;
    int e_need;
    logic [5:0] e_ctl;   // {pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush}
    logic [1:0] e_fa, e_fb;

    always #5 clk = ~clk;

    hazard_ctl #(.REGW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dest      (ex_dest),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .pc_src       (pc_src),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit produces(bit we, logic [4:0] dest, logic [4:0] r);
        return we && (dest != 5'd0) && (dest == r);
    endfunction

    function automatic bit feeds_id(bit we, logic [4:0] dest);
        return produces(we, dest, id_rs) || (id_uses_rt && produces(we, dest, id_rt));
    endfunction

    function automatic logic [1:0] fwd_sel(logic [4:0] r);
        if (produces(mem_regwrite, mem_dest, r)) return 2'b10;
        if (produces(wb_regwrite, wb_dest, r))   return 2'b01;
        return 2'b00;
    endfunction

    task automatic compute();
`ifdef HAZARD_CTL_FORWARDING_EN
        e_need = (ex_memread && feeds_id(ex_regwrite, ex_dest)) ? 1 : 0;
        e_fa   = fwd_sel(ex_rs);
        e_fb   = fwd_sel(ex_rt);
`else
        e_need = feeds_id(ex_regwrite, ex_dest) ? 2 : (feeds_id(mem_regwrite, mem_dest) ? 1 : 0);
        e_fa   = 2'b00;
        e_fb   = 2'b00;
`endif
        if (rst) begin
            stall_left = 0;
            m_stall    = 0;
            m_flush    = 0;
            e_ctl      = 6'b000000;
            e_fa       = 2'b00;
            e_fb       = 2'b00;
        end else if (branch_taken) begin
            e_ctl = 6'b111111;
        end else if (stall_left > 0 || e_need > 0) begin
            e_ctl = 6'b000010;
        end else begin
            e_ctl = 6'b110000;
        end
    endtask

    // Called just after a falling edge with inputs applied; returns at the next one.
    task automatic cycle();
        #1;
        compute();
        check("ctl", 32'({pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush}), 32'(e_ctl));
        check("fwd", 32'({fwd_a, fwd_b}), 32'({e_fa, e_fb}));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_events", 32'(flush_events), 32'(m_flush));
        @(posedge clk);
        if (rst) begin
            stall_left = 0;
            m_stall    = 0;
            m_flush    = 0;
        end else begin
            if (!e_ctl[5] && m_stall < 65535) m_stall++;
            if (branch_taken && m_flush < 65535) m_flush++;
            if (branch_taken)        stall_left = 0;
            else if (stall_left > 0) stall_left--;
            else if (e_need > 0)     stall_left = e_need - 1;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_dest = 5'd0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_dest = 5'd0; mem_regwrite = 1'b0;
        wb_dest = 5'd0; wb_regwrite = 1'b0;
        branch_taken = 1'b0;
    endtask

    // A hazard that stalls under either build.
    task automatic set_load_hazard();
        clear_inputs();
        id_rs = 5'd8; ex_dest = 5'd8; ex_regwrite = 1'b1; ex_memread = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        cycle();
        cycle();
        check("reset_pc_write", 32'(pc_write), 32'd0);
        rst = 1'b0;

        // Randomized traffic over a small register set so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_dest      = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            mem_dest     = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_dest      = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 7) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        clear_inputs();
        cycle();

`ifdef HAZARD_CTL_FORWARDING_EN
        // Load-use: exactly one bubble.
        base = m_stall;
        set_load_hazard();
        #1;
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_idex_flush", 32'(idex_flush), 32'd1);
        cycle();
        clear_inputs();
        #1;
        check("lu_resume", 32'(pc_write), 32'd1);
        check("lu_stall_count", 32'(stall_cycles), 32'(base + 1));
        cycle();

        // Forwarding priority and register-0 exclusion.
        clear_inputs();
        mem_dest = 5'd5; wb_dest = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd5;
        #1;
        check("fwd_mem", 32'(fwd_a), 32'd2);
        cycle();
        mem_regwrite = 1'b0;
        #1;
        check("fwd_wb", 32'(fwd_a), 32'd1);
        cycle();
        mem_regwrite = 1'b1; mem_dest = 5'd0; wb_dest = 5'd0; ex_rs = 5'd0;
        #1;
        check("fwd_r0", 32'(fwd_a), 32'd0);
        cycle();
`else
        // Interlock on an EX producer: two bubbles, then RUN.
        base = m_stall;
        clear_inputs();
        ex_dest = 5'd9; ex_regwrite = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        check("il_first", 32'(pc_write), 32'd0);
        cycle();
        clear_inputs();
        #1;
        check("il_second", 32'(pc_write), 32'd0);
        cycle();
        #1;
        check("il_resume", 32'(pc_write), 32'd1);
        check("il_stall_count", 32'(stall_cycles), 32'(base + 2));
        cycle();
`endif

        // Taken branch overrides a stall in progress.
        set_load_hazard();
        cycle();
        branch_taken = 1'b1;
        base = m_flush;
        #1;
        check("br_pc_src", 32'(pc_src), 32'd1);
        check("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush}), 32'd7);
        check("br_pc_write", 32'(pc_write), 32'd1);
        cycle();
        clear_inputs();
        #1;
        check("br_run", 32'(pc_write), 32'd1);
        check("br_flush_count", 32'(flush_events), 32'(base + 1));
        cycle();

        // Reset in the middle of a stall.
        set_load_hazard();
        mem_dest = 5'd3; mem_regwrite = 1'b1; ex_rs = 5'd3;
        cycle();
        rst = 1'b1;
        #1;
        check("rst_ctl", 32'({pc_write, ifid_write, pc_src, ifid_flush, idex_flush, exmem_flush}), 32'd0);
        check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check("rst_counters", 32'({stall_cycles, flush_events}), 32'd0);
        cycle();
        rst = 1'b0;
        clear_inputs();
        #1;
        check("rst_release", 32'(pc_write), 32'd1);
        cycle();

        // Long stall saturates the stall counter.
        set_load_hazard();
        for (int i = 0; i < 70000; i++) begin
            cycle();
        end
        #1;
        check("stall_saturate", 32'(stall_cycles), 32'h0000FFFF);
        clear_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 Parameter REGW, default 5, register-address width of all *_rs/*_rt/*_dest ports.
REQ-002 clk  input  1  rising-edge clock; the only clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 id_rs, id_rt  input  REGW each  source registers of the instruction in IF/ID; id_uses_rt  input  1  high when rt is a read operand.
REQ-005 ex_rs, ex_rt  input  REGW each  source registers of the instruction in ID/EX (forwarding compare).
REQ-006 ex_dest  input  REGW, ex_regwrite  input  1, ex_memread  input  1  ID/EX destination, write enable, load flag.
REQ-007 mem_dest  input  REGW, mem_regwrite  input  1  EX/MEM destination and write enable.
REQ-008 wb_dest  input  REGW, wb_regwrite  input  1  MEM/WB destination and write enable.
REQ-009 branch_taken  input  1  EX/MEM branch AND zero.
REQ-010 pc_write, ifid_write  output  1 each  PC and IF/ID load enables.
REQ-011 pc_src  output  1  select EX/MEM branch target as next PC.
REQ-012 ifid_flush, idex_flush, exmem_flush  output  1 each  zero the named pipeline register's control fields (bubble).
REQ-013 fwd_a, fwd_b  output  2 each  ALU operand source: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
REQ-014 stall_cycles, flush_events  output  16 each  saturating performance counters.

Function
REQ-015 Producer P SHALL match operand r when P's regwrite=1, P's dest!=0, and P's dest==r; id_rt is compared only when id_uses_rt=1.
REQ-016 FSM SHALL have states RUN and STALL plus a 2-bit down-counter cnt.
REQ-017 In RUN, hazard need n SHALL be: with FORWARDING_EN, n=1 if ex_memread and ID/EX matches an ID operand, else 0; without it, n=2 if ID/EX matches, else 1 if EX/MEM matches, else 0.
REQ-018 In RUN with n>0 and branch_taken=0: pc_write=0, ifid_write=0, idex_flush=1 in the same cycle; if n=2, next state STALL with cnt=1, otherwise remain RUN.
REQ-019 In STALL: pc_write=0, ifid_write=0, idex_flush=1; cnt decrements each cycle; return to RUN on the edge where cnt=0; no new hazard evaluation occurs in STALL.
REQ-020 When no stall and no branch: pc_write=1, ifid_write=1, all flushes 0, pc_src=0.
REQ-021 branch_taken=1 in any state SHALL give pc_src=1, pc_write=1, ifid_write=1, ifid_flush=idex_flush=exmem_flush=1 that cycle, next state RUN, cnt=0; it overrides any stall.
REQ-022 fwd_a SHALL be 10 if EX/MEM matches ex_rs, else 01 if MEM/WB matches ex_rs, else 00; fwd_b is the same on ex_rt; EX/MEM has priority on double match.
REQ-023 stall_cycles SHALL increment by one per cycle with pc_write=0; flush_events by one per cycle with branch_taken=1; both saturate at 16'hFFFF.
REQ-024 WB-stage producers never stall: regfile write-before-read is provided by the regfile.

Reset
REQ-025 While rst=1: state RUN, cnt=0, counters 0, pc_write=0, ifid_write=0, pc_src=0, all flushes 0, fwd_a=fwd_b=00.
REQ-026 rst asserting mid-STALL SHALL abort the stall immediately; first post-reset cycle is evaluated in RUN.

Configuration
REQ-027 Macro HAZARD_CTL_FORWARDING_EN: defined selects the forwarding rules of REQ-017 (n=1) and REQ-022.
REQ-028 Undefined: n from the no-forwarding rule of REQ-017, fwd_a=fwd_b=00 constantly, and the forwarding sub-module is not instantiated.

Structure
REQ-029 Shared package hazard_pkg SHALL hold the state enum (RUN, STALL) and constants FWD_REG=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01.
REQ-030 Forwarding compare logic SHALL be a sub-module fwd_unit; FSM, counters and stall/flush logic stay in hazard_ctl.

Verification
REQ-031 Forwarding on: ex_memread=1, ex_dest=8, ex_regwrite=1, id_rs=8 -> one cycle pc_write=0, idex_flush=1; next cycle pc_write=1; stall_cycles=1.
REQ-032 Forwarding off: ex_dest=9 with ex_regwrite=1, id_rt=9, id_uses_rt=1 -> exactly 2 cycles pc_write=0, then RUN.
REQ-033 Forwarding on: mem_dest=wb_dest=5, both regwrite=1, ex_rs=5 -> fwd_a=10; same with mem_regwrite=0 -> fwd_a=01; dest 0 -> fwd_a=00.
REQ-034 branch_taken=1 during the second STALL cycle -> pc_src=1, all three flushes 1, pc_write=1; next cycle RUN; flush_events increments.
REQ-035 rst pulse mid-STALL -> outputs at reset values immediately, counters 0; after release with no hazard, pc_write=1.
REQ-036 Force a stall for 70000 cycles -> stall_cycles holds 16'hFFFF without wrapping.
